// File: rtl/data_sram_resp.sv
// Wait-state responder for the M-stage data-SRAM port: one latched access per request after LATENCY cycles.
// Optional byte-enable legality check and addr_err output are enabled by defining DSRAM_WEN_CHK_EN.
module data_sram_resp #(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        longest_stall,
  output logic [31:0] data_sram_rdata,
  output logic        d_stall,
  output logic [1:0]  state_dbg
`ifdef DSRAM_WEN_CHK_EN
  ,
  output logic        addr_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              cnt;
  logic [3:0]              wen_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic                    accept;
  logic                    fire;
  logic                    wen_ok;
  logic                    do_write;
  logic                    unused_addr_bits;

  logic [31:0] mem [2**DEPTH_LOG2];

  assign state_dbg        = state;
  assign accept           = (state == IDLE) && data_sram_en;
  assign fire             = (state == BUSY) && (cnt == 4'd0);
  assign unused_addr_bits = &{1'b0, data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

`ifdef DSRAM_WEN_CHK_EN
  always_comb begin
    wen_ok = 1'b0;
    case (wen_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: wen_ok = 1'b1;
      default:                            wen_ok = 1'b0;
    endcase
  end
`else
  assign wen_ok = 1'b1;
`endif

  // A reset in the firing cycle must discard the pending write.
  assign do_write = fire && !rst && (wen_q != 4'b0000) && wen_ok;

  always_comb begin
    state_nxt = state;
    d_stall   = 1'b0;
    case (state)
      IDLE: begin
        d_stall = data_sram_en;
        if (data_sram_en) state_nxt = BUSY;
      end
      BUSY: begin
        d_stall = 1'b1;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        if (!longest_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      data_sram_rdata <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (fire && (wen_q == 4'b0000)) begin
        data_sram_rdata <= mem[idx_q];
      end
    end
  end

`ifdef DSRAM_WEN_CHK_EN
  // Registered so the pulse lines up with the first DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= fire && !wen_ok;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      wen_q   <= data_sram_wen;
      idx_q   <= data_sram_addr[DEPTH_LOG2+1:2];
      wdata_q <= data_sram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
